// File: rtl/load_filter.sv
// MIPS load formatter: one word-aligned bus read per request, then byte/halfword
// extraction with sign/zero extension or LWL/LWR merge into rt.
module load_filter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] rt_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out,
    output logic        err,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state_q;
    logic [5:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] rt_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [3:0]  be_d;
    logic        done_q;
    logic        err_q;
    logic        read_q;
    logic        legal_d;

    function automatic logic is_legal(input logic [5:0] o, input logic [1:0] b);
        case (o)
            OP_LB, OP_LBU, OP_LWL, OP_LWR: return 1'b1;
            OP_LH, OP_LHU:                 return ~b[0];
            OP_LW:                         return (b == 2'b00);
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [5:0] o, input logic [1:0] b);
        case (o)
            OP_LB, OP_LBU: return 4'b0001 << b;
            OP_LH, OP_LHU: return b[1] ? 4'b1100 : 4'b0011;
            default:       return 4'b1111;
        endcase
    endfunction

    // Little-endian lanes: offset b lives in m[8b+7:8b].
    function automatic logic [31:0] format_load(input logic [5:0] o, input logic [1:0] b,
                                                input logic [31:0] r, input logic [31:0] m);
        logic signed [7:0]  by;
        logic signed [15:0] hw;
        by = m[{b, 3'b000} +: 8];
        hw = b[1] ? m[31:16] : m[15:0];
        case (o)
            OP_LB:  return {{24{by[7]}}, by};
            OP_LBU: return {24'h0, by};
            OP_LH:  return {{16{hw[15]}}, hw};
            OP_LHU: return {16'h0, hw};
            OP_LWL: begin
                case (b)
                    2'd0:    return {m[7:0], r[23:0]};
                    2'd1:    return {m[15:0], r[15:0]};
                    2'd2:    return {m[23:0], r[7:0]};
                    default: return m;
                endcase
            end
            OP_LWR: begin
                case (b)
                    2'd0:    return m;
                    2'd1:    return {r[31:24], m[31:8]};
                    2'd2:    return {r[31:16], m[31:16]};
                    default: return {r[31:8], m[31:24]};
                endcase
            end
            default: return m;
        endcase
    endfunction

    always_comb begin
        legal_d = is_legal(op, addr[1:0]);
        be_d    = lane_mask(op, addr[1:0]);
        data_d  = format_load(op_q, off_q, rt_q, mem_readdata);
        cnt_d   = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            off_q   <= '0;
            rt_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            read_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (legal_d) begin
                            state_q <= REQ;
                            op_q    <= op;
                            off_q   <= addr[1:0];
                            rt_q    <= rt_in;
                            addr_q  <= {addr[31:2], 2'b00};
                            be_q    <= be_d;
                            cnt_q   <= '0;
                            err_q   <= 1'b0;
                            read_q  <= 1'b1;
                        end else begin
                            // Rejected up front: no bus cycle, previous data_out kept.
                            state_q <= RESP;
                            err_q   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (!mem_waitrequest) begin
                        data_q  <= data_d;
                        read_q  <= 1'b0;
                        state_q <= RESP;
                    end else if (TIMEOUT_CYCLES != 0 && cnt_d == TIMEOUT_CYCLES) begin
                        read_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign data_out       = data_q;
    assign err            = err_q;
    assign mem_address    = addr_q;
    assign mem_read       = read_q;
    assign mem_byteenable = be_q;

endmodule

// File: tb/tb_load_filter.sv
// Bench for load_filter: directed loads against a transaction-level reference
// model, checked every cycle, plus literal expectations for the listed cases.
module tb_load_filter;

    localparam int TMO = 4;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  op = '0;
    logic [31:0] addr = '0;
    logic [31:0] rt_in = '0;
    logic        busy, done, err, mem_read;
    logic [31:0] data_out, mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest = 1'b1;
    logic [31:0] mem_readdata = '0;

    load_filter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .rt_in(rt_in),
        .busy(busy), .done(done), .data_out(data_out), .err(err),
        .mem_address(mem_address), .mem_read(mem_read), .mem_byteenable(mem_byteenable),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int done_cyc = -1;
    bit chk_en = 1'b0;

    logic        exp_busy = 1'b0, exp_done = 1'b0, exp_read = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_data = '0, exp_addr = '0;
    logic [3:0]  exp_be = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: what a MIPS load returns, from byte arithmetic on the word.
    function automatic bit model_legal(input logic [5:0] o, input logic [31:0] a);
        if (o == OP_LB || o == OP_LBU || o == OP_LWL || o == OP_LWR) return 1'b1;
        if (o == OP_LH || o == OP_LHU) return (a % 2) == 0;
        if (o == OP_LW) return (a % 4) == 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_be(input logic [5:0] o, input logic [31:0] a);
        int b;
        b = a % 4;
        if (o == OP_LB || o == OP_LBU) return 4'(1 << b);
        if (o == OP_LH || o == OP_LHU) return 4'(3 << b);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_fmt(input logic [5:0] o, input logic [31:0] a,
                                              input logic [31:0] r, input logic [31:0] m);
        longint unsigned mm, rr, byt, half, keep;
        int b;
        b = a % 4;
        mm = 64'(m);
        rr = 64'(r);
        byt  = (mm >> (8 * b)) & 64'hFF;
        half = (mm >> (8 * b)) & 64'hFFFF;
        case (o)
            OP_LB:  return (byt >= 64'h80) ? 32'(byt + 64'hFFFF_FF00) : 32'(byt);
            OP_LBU: return 32'(byt);
            OP_LH:  return (half >= 64'h8000) ? 32'(half + 64'hFFFF_0000) : 32'(half);
            OP_LHU: return 32'(half);
            OP_LWL: begin
                keep = (64'd1 << (8 * (3 - b))) - 64'd1;
                return 32'(((mm << (8 * (3 - b))) & 64'hFFFF_FFFF) | (rr & keep));
            end
            OP_LWR: begin
                keep = 64'hFFFF_FFFF & ~(64'hFFFF_FFFF >> (8 * b));
                return 32'((mm >> (8 * b)) | (rr & keep));
            end
            default: return m;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_read) rd_cnt++;
        if (done) done_cyc = cyc;
        if (chk_en) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("mem_read", 32'(mem_read), 32'(exp_read));
            check("data_out", data_out, exp_data);
            if (exp_done) check("err", 32'(err), 32'(exp_err));
            if (exp_read) begin
                check("mem_address", mem_address, exp_addr);
                check("mem_byteenable", 32'(mem_byteenable), 32'(exp_be));
            end
        end
    end

    task automatic do_load(input logic [5:0] o, input logic [31:0] a, input logic [31:0] r,
                           input logic [31:0] m, input int waits, input bit stuck,
                           input bit poke, input int exp_rd, input int exp_lat);
        int  start_ref;
        int  stalls;
        bit  wait_now;
        op = o; addr = a; rt_in = r; start = 1'b1;
        mem_waitrequest = 1'b1; mem_readdata = 32'hDEAD_BEEF;
        rd_cnt = 0; done_cyc = -1; start_ref = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0; op = 6'b0; addr = 32'hFFFF_FFFF; rt_in = 32'h5555_5555;
        if (!model_legal(o, a)) begin
            exp_busy = 1'b1;
            @(posedge clk); #1;
            exp_busy = 1'b0; exp_done = 1'b1; exp_err = 1'b1;
        end else begin
            exp_busy = 1'b1; exp_read = 1'b1; exp_err = 1'b0;
            exp_addr = {a[31:2], 2'b00}; exp_be = model_be(o, a);
            stalls = 0;
            for (int k = 0; k < 100; k++) begin
                wait_now = stuck || (k < waits);
                mem_waitrequest = wait_now;
                mem_readdata = wait_now ? 32'hDEAD_BEEF : m;
                if (poke && k == 1) begin
                    start = 1'b1; op = OP_LW; addr = 32'h0000_0F00;
                end
                @(posedge clk); #1;
                start = 1'b0;
                if (!wait_now) begin
                    exp_read = 1'b0; exp_data = model_fmt(o, a, r, m);
                    break;
                end
                stalls++;
                if (stalls == TMO) begin
                    exp_read = 1'b0; exp_err = 1'b1;
                    break;
                end
            end
            mem_waitrequest = 1'b1; mem_readdata = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            exp_busy = 1'b0; exp_done = 1'b1;
        end
        @(posedge clk); #1;
        exp_done = 1'b0;
        check("rd_cycles", 32'(rd_cnt), 32'(exp_rd));
        check("latency", 32'(done_cyc - start_ref), 32'(exp_lat));
    endtask

    initial begin
        check("m_lb",  model_fmt(OP_LB,  32'h1003, 32'h0, 32'h80FF_1234), 32'hFFFF_FF80);
        check("m_lhu", model_fmt(OP_LHU, 32'h2002, 32'h0, 32'hBEEF_0011), 32'h0000_BEEF);
        check("m_lwl", model_fmt(OP_LWL, 32'h3001, 32'hAABB_CCDD, 32'h1122_3344), 32'h3344_CCDD);
        check("m_lwr", model_fmt(OP_LWR, 32'h3001, 32'hAABB_CCDD, 32'h1122_3344), 32'hAA11_2233);
        check("m_lwr3", model_fmt(OP_LWR, 32'h3003, 32'hAABB_CCDD, 32'h1122_3344), 32'hAABB_CC11);

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_read", 32'(mem_read), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_be", 32'(mem_byteenable), 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        do_load(OP_LB, 32'h1003, 32'h0, 32'h80FF_1234, 0, 1'b0, 1'b0, 1, 2);
        check("lb_data", data_out, 32'hFFFF_FF80);
        do_load(OP_LHU, 32'h2002, 32'h0, 32'hBEEF_0011, 3, 1'b0, 1'b0, 4, 5);
        check("lhu_data", data_out, 32'h0000_BEEF);
        do_load(OP_LWL, 32'h3001, 32'hAABB_CCDD, 32'h1122_3344, 0, 1'b0, 1'b0, 1, 2);
        check("lwl_data", data_out, 32'h3344_CCDD);
        do_load(OP_LWR, 32'h3001, 32'hAABB_CCDD, 32'h1122_3344, 1, 1'b0, 1'b0, 2, 3);
        check("lwr_data", data_out, 32'hAA11_2233);
        do_load(OP_LW, 32'h4002, 32'h0, 32'h1234_5678, 0, 1'b0, 1'b0, 0, 1);
        check("lw_mis_data", data_out, 32'hAA11_2233);
        do_load(6'b101011, 32'h4000, 32'h0, 32'h1234_5678, 0, 1'b0, 1'b0, 0, 1);
        check("illegal_err", 32'(err), 32'd1);
        do_load(OP_LH, 32'h6002, 32'h0, 32'h8001_0000, 2, 1'b0, 1'b0, 3, 4);
        check("lh_data", data_out, 32'hFFFF_8001);
        do_load(OP_LH, 32'h6001, 32'h0, 32'h8001_0000, 0, 1'b0, 1'b0, 0, 1);
        do_load(OP_LBU, 32'h7001, 32'h0, 32'h0000_9A00, 0, 1'b0, 1'b0, 1, 2);
        check("lbu_data", data_out, 32'h0000_009A);
        do_load(OP_LB, 32'h7000, 32'h0, 32'hFFFF_FF7F, 0, 1'b0, 1'b0, 1, 2);
        do_load(OP_LWL, 32'h3000, 32'hAABB_CCDD, 32'h1122_3344, 0, 1'b0, 1'b0, 1, 2);
        check("lwl0_data", data_out, 32'h44BB_CCDD);
        do_load(OP_LWR, 32'h3003, 32'hAABB_CCDD, 32'h1122_3344, 0, 1'b0, 1'b0, 1, 2);
        do_load(OP_LW, 32'h4000, 32'h0, 32'h1234_5678, 0, 1'b1, 1'b1, 4, 5);
        check("tmo_data", data_out, 32'hAABB_CC11);
        do_load(OP_LW, 32'h4004, 32'h0, 32'h0BAD_CAFE, 3, 1'b0, 1'b0, 4, 5);

        // Reset in the middle of a stalled read.
        op = OP_LW; addr = 32'h5000; start = 1'b1; mem_waitrequest = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_busy = 1'b1; exp_read = 1'b1; exp_addr = 32'h5000; exp_be = 4'hF; exp_err = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_busy = 1'b0; exp_read = 1'b0; exp_data = 32'h0;
        check("mid_rst_addr", mem_address, 32'd0);
        check("mid_rst_be", 32'(mem_byteenable), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        reset = 1'b0; mem_waitrequest = 1'b0; mem_readdata = 32'h1234_5678; done_cyc = -1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
        do_load(OP_LW, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 1, 2);
        check("post_rst_lw", data_out, 32'hCAFE_F00D);

        // start together with reset: reset wins.
        op = OP_LW; addr = 32'h0; start = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0; exp_data = 32'h0;
        @(posedge clk); #1;
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_read", 32'(mem_read), 32'd0);
        @(posedge clk); #1;

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_filter.md
Name: load_filter

Overview:
- Read-side counterpart of the CPU's store-data formatter. Executes one MIPS load per request over the word-aligned Avalon-style data bus.
- Issues the read, waits out waitrequest, then extracts the byte or halfword, sign- or zero-extends it, or merges LWL/LWR bytes into rt.
- Sits between the CPU memory stage and the data bus. Returns a registered result with a one-cycle done pulse.

Parameters:
TIMEOUT_CYCLES, 255, max consecutive cycles of waitrequest=1 tolerated before abort with err; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request strobe, sampled only in IDLE
op  input  6  load opcode: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110
addr  input  32  effective byte address, sampled with start
rt_in  input  32  current rt value for LWL/LWR merge, sampled with start
busy  output  1  high in every state other than IDLE
done  output  1  one-cycle pulse: data_out/err valid
data_out  output  32  formatted load result, held until next done
err  output  1  valid with done: misaligned, illegal op or timeout
mem_address  output  32  {addr[31:2],2'b00}
mem_read  output  1  read request
mem_byteenable  output  4  active byte lanes
mem_waitrequest  input  1  slave stall
mem_readdata  input  32  read data, valid when mem_read=1 and mem_waitrequest=0

Behaviour:
- Reset values: busy=0, done=0, err=0, data_out=0, mem_read=0, mem_address=0, mem_byteenable=0, state=IDLE, timeout counter=0.
- States: IDLE, REQ, RESP.
- IDLE to REQ on start=1 with a legal op and aligned address:
  - Latch op, addr[1:0] and rt_in.
  - mem_read=1 from the next cycle.
- IDLE to RESP on start=1 with an illegal op, LH/LHU with addr[0]=1, or LW with addr[1:0]≠0:
  - No bus read is issued.
  - err=1; data_out keeps its previous value.
- REQ:
  - Hold mem_read, mem_address and mem_byteenable constant.
  - When mem_waitrequest=0, capture mem_readdata, drop mem_read on the next edge and go to RESP.
  - Each cycle with waitrequest=1 increments the counter. When the counter reaches TIMEOUT_CYCLES (nonzero), drop mem_read and go to RESP with err=1 and data_out unchanged.
- RESP: done=1 for exactly one cycle, then IDLE. start is ignored in RESP and REQ.
- Minimum latency:
  - start at edge N → mem_read high after N.
  - Zero-wait slave → done high after N+2.
  - Each wait cycle adds 1.
- Byte lanes are little-endian: offset b maps to readdata[8b+7:8b].
- Byte enables:
  - LB/LBU: one-hot 1<<b.
  - LH/LHU: 0011 for b=0, 1100 for b=2.
  - LW/LWL/LWR: 1111.
- Extraction:
  - LB: sign-extend byte b.
  - LBU: zero-extend byte b.
  - LH: sign-extend half b[1].
  - LHU: zero-extend half b[1].
  - LW: full word.
- LWL (m=readdata, r=rt):
  - b0 {m[7:0],r[23:0]}
  - b1 {m[15:0],r[15:0]}
  - b2 {m[23:0],r[7:0]}
  - b3 m
- LWR:
  - b0 m
  - b1 {r[31:24],m[31:8]}
  - b2 {r[31:16],m[31:16]}
  - b3 {r[31:8],m[31:24]}
- LWL/LWR never raise misalignment.
- data_out and err update only on the edge entering RESP. err is cleared on the next accepted start.
- Reset asserted mid-transaction: the next edge returns to IDLE with mem_read=0, no done, and all outputs at reset values. A late readdata is ignored.
- start asserted together with reset: reset wins.

Test Plan:
- LB addr=0x1003, readdata=0x80FF_1234, zero wait → mem_read one cycle, mem_byteenable=1000, data_out=0xFFFF_FF80, done two cycles after start.
- LHU addr=0x2002, readdata=0xBEEF_0011, three wait cycles → mem_read held 4 cycles, mem_byteenable=1100, data_out=0x0000_BEEF, done at start+5.
- LWL addr=0x3001, rt=0xAABB_CCDD, readdata=0x1122_3344 → data_out=0x3344_CCDD; LWR same address → 0xAA11_2233.
- LW addr=0x4002 → mem_read never asserted, done next-but-one cycle with err=1, data_out unchanged; op=6'b101011 likewise err=1.
- TIMEOUT_CYCLES=4, waitrequest stuck high → mem_read dropped after 4 stall cycles, done with err=1; second start during REQ ignored.
- Reset asserted in REQ → mem_read=0 next cycle, no done, data_out=0; a subsequent LW addr=0x0 completes normally.
